// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose:
//   Adds two W-bit operands (W = 4*NIBBLES) using a single 4-bit ripple-carry
//   slice (RCA_4bit). The slice is used once per clock, least-significant
//   nibble first. The carry between nibbles is held in a register. A
//   start/busy/done handshake returns the full-width sum and the final carry.
//
// Optional feature (macro NSA_SUB_EN):
//   When defined, a 'sub' input is added. With sub=1 the block computes
//   A-B mod 2^W. The slice sees ~B and the initial carry is forced to 1.
//   In that mode cout=1 means no borrow occurred. When the macro is undefined
//   the block adds only, and no inversion logic exists.
//
// Parameters:
//   NIBBLES  operand width in nibbles (legal range 1..16), W = 4*NIBBLES
//
// Ports:
//   clk    in   1  sole clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  request, sampled only in IDLE
//   a      in   W  operand A, latched when start is accepted
//   b      in   W  operand B, latched when start is accepted
//   cin    in   1  carry into nibble 0, latched when start is accepted
//   sub    in   1  subtract select (only when NSA_SUB_EN is defined)
//   busy   out  1  high while nibbles are being added
//   done   out  1  single-cycle pulse; sum/cout are final
//   sum    out  W  result register
//   cout   out  1  carry out of the top nibble
// ---------------------------------------------------------------------------

// Plain 4-bit ripple-carry adder slice.
module RCA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = w_c[4];

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef NSA_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  // The nibble index needs at least one bit, even when NIBBLES=1.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_cout;
  logic          r_busy;
  logic          r_done;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [3:0]    w_slice_sum;
  logic          w_slice_cout;
  logic          w_init_carry;

  assign w_a_nib = r_a[4*r_idx +: 4];

`ifdef NSA_SUB_EN
  logic r_sub;
  // In subtract mode, B is inverted and the initial carry is 1. This gives
  // A + ~B + 1, which equals A - B.
  assign w_b_nib      = r_b[4*r_idx +: 4] ^ {4{r_sub}};
  assign w_init_carry = sub ? 1'b1 : cin;
`else
  assign w_b_nib      = r_b[4*r_idx +: 4];
  assign w_init_carry = cin;
`endif

  RCA_4bit u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef NSA_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
            r_carry <= w_init_carry;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef NSA_SUB_EN
            r_sub   <= sub;
`endif
          end
        end

        S_RUN: begin
          r_sum[4*r_idx +: 4] <= w_slice_sum;
          r_carry             <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            // The top nibble's carry becomes the result carry.
            r_cout  <= w_slice_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential wide-operand adder that drives a single 4-bit ripple-carry slice (`RCA_4bit`: a, b, cin → sum, cout) once per clock, least-significant nibble first, and carries between nibbles in a register. It sits directly upstream of the 4-bit adder, sequencing operand nibbles into it and collecting its sum/cout outputs. A start/busy/done handshake delivers a full-width sum and final carry.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  W  operand A; latched on start acceptance.
- `b`  in  W  operand B; latched on start acceptance.
- `cin`  in  1  carry into nibble 0; latched on start acceptance.
- `sub`  in  1  subtract select; present only with `NSA_SUB_EN`.
- `busy`  out  1  high while nibbles are being added.
- `done`  out  1  single-cycle pulse; `sum`/`cout` are final.
- `sum`  out  W  result register.
- `cout`  out  1  carry out of the top nibble.

## Operation
- Exactly one `RCA_4bit` instance. No wide combinational adder.
- States:
  - IDLE: `start`=1 → RUN. Latch `a`, `b`, `cin`. Clear `sum`, `cout` and the nibble index; set the carry register to `cin`.
  - RUN: each cycle, the slice adds nibble[idx] of A and B with the carry register. At the edge, write the slice sum into `sum[4*idx+3:4*idx]`, load the carry register from slice cout, and increment idx. When idx = NIBBLES-1, also load `cout` and go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE unconditionally.
- `start` is ignored in RUN and DONE. It is not queued.
- Changes on `a`/`b`/`cin` after acceptance have no effect.
- `sum` and `cout` hold after DONE until the next accepted start clears them.
- `sum` is only valid from the `done` cycle onward. During RUN, partially written nibbles are visible.
- Result is modulo 2^W. `cout` is the true carry out of bit W-1.
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0; state IDLE; idx 0; carry register 0.
- Reset takes priority over `start`.
- Reset mid-RUN aborts the operation: no `done` is issued, and outputs return to their reset values on the next edge.

## Timing
- `start` sampled high at edge 0.
- `busy`=1 in cycles 1..NIBBLES.
- `done`=1 in cycle NIBBLES+1, with `busy`=0.
- Latency from start to done is NIBBLES+1 edges. For NIBBLES=1, `done` is asserted in cycle 2.
- Earliest next start is sampled at edge NIBBLES+2 (in IDLE).
- Throughput is one operation per NIBBLES+2 cycles.
- Slice path: carry register → `RCA_4bit` → sum/carry registers. This is a single 4-bit ripple per cycle, independent of NIBBLES.

## Configuration
- `NSA_SUB_EN` defined:
  - Port `sub` exists and is latched with the operands.
  - When `sub`=1, the slice receives ~B nibbles and the initial carry is forced to 1; `cin` is ignored.
  - Result is A−B mod 2^W. `cout`=1 means no borrow.
  - When `sub`=0, behaviour is identical to add mode.
- `NSA_SUB_EN` undefined:
  - No `sub` port; the block is add-only.
  - No inversion logic is synthesized.

## Test plan
All scenarios use NIBBLES=4.
- a=16'h1234, b=16'h4321, cin=0, start pulse → `busy` in cycles 1–4; `done` in cycle 5 with `sum`=16'h5555, `cout`=0.
- a=16'hFFFF, b=16'h0001, cin=0 → `sum`=16'h0000, `cout`=1. Confirms the carry propagates through all four nibbles.
- a=16'hFFFF, b=16'hFFFF, cin=1 → `sum`=16'hFFFF, `cout`=1.
- Start a=16'h0010, b=16'h0020, then in cycle 2 pulse `start` with a=16'hAAAA, b=16'h1111 → only one `done`, `sum`=16'h0030. The second start is ignored.
- Start a=16'h1111, b=16'h1111; assert `rst` in cycle 2 → cycle 3 shows `busy`=0, `sum`=0, and no `done` follows. A later start with a=16'h0001, b=16'h0002 completes with `sum`=16'h0003.
- With `NSA_SUB_EN`: a=16'h0005, b=16'h0007, sub=1 → `sum`=16'hFFFE, `cout`=0. Then a=16'h0007, b=16'h0005, sub=1 → `sum`=16'h0002, `cout`=1.
